// File: rtl/sync_rx_if.sv
// SYNC monitor bus: the raw SYNC line in, measurement and status pulses out.
interface sync_rx_if #(
  parameter int unsigned CNT_W = 10
);
  logic             sync_in;
  logic             sync_rise;
  logic [CNT_W-1:0] period;
  logic             period_vld;
  logic             locked;
  logic             err;
  logic             timeout;

  modport master (
    input  sync_in,
    output sync_rise, period, period_vld, locked, err, timeout
  );

  modport slave (
    output sync_in,
    input  sync_rise, period, period_vld, locked, err, timeout
  );
endinterface

// File: rtl/sync_rx_monitor.sv
// Receive-side SYNC checker: synchronises SYNC, measures rise-to-rise period,
// tracks lock over consecutive good periods and flags period errors and loss of SYNC.
module sync_rx_monitor #(
  parameter int unsigned NOM_PERIOD = 184,
  parameter int unsigned TOL        = 4,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned TIMEOUT    = 368,
  parameter int unsigned CNT_W      = 10
) (
  input logic       clk,
  input logic       rst,
  sync_rx_if.master bus
);

  localparam int unsigned GC_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned EW   = CNT_W + 1;

  localparam logic [EW-1:0]    LO_LIM  = EW'(NOM_PERIOD - TOL);
  localparam logic [EW-1:0]    HI_LIM  = EW'(NOM_PERIOD + TOL);
  localparam logic [EW-1:0]    TMO_LIM = EW'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [GC_W-1:0]  GC_LOCK = GC_W'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

  state_t           state, state_n;
  logic             s1, s2, s3;
  logic             rise_c;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [EW-1:0]    cnt_p1_c;
  logic             good_c;
  logic [GC_W-1:0]  good_cnt, good_cnt_n, good_inc_c;

  logic             sync_rise_q, period_vld_q, period_vld_n;
  logic             locked_q, err_q, err_n, timeout_q, timeout_n;
  logic [CNT_W-1:0] period_q, period_n;

  assign rise_c     = s2 & ~s3;
  assign cnt_p1_c   = {1'b0, cnt} + EW'(1);
  assign good_c     = (cnt_p1_c >= LO_LIM) && (cnt_p1_c <= HI_LIM);
  assign good_inc_c = good_cnt + GC_W'(1);

  // Next-state and next-output logic; a rise always takes priority over timeout.
  always_comb begin
    state_n      = state;
    good_cnt_n   = good_cnt;
    cnt_n        = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    period_n     = period_q;
    period_vld_n = 1'b0;
    err_n        = 1'b0;
    timeout_n    = 1'b0;

    if (rise_c) begin
      cnt_n = '0;
      if (state != IDLE) begin
        period_vld_n = 1'b1;
        period_n     = CNT_W'(cnt_p1_c);
      end
      case (state)
        IDLE: begin
          state_n    = ACQ;
          good_cnt_n = '0;
        end
        ACQ: begin
          if (good_c) begin
            good_cnt_n = good_inc_c;
            if (good_inc_c == GC_LOCK) state_n = LOCKED;
          end else begin
            err_n      = 1'b1;
            good_cnt_n = '0;
          end
        end
        LOCKED: begin
          if (!good_c) begin
            err_n      = 1'b1;
            state_n    = ACQ;
            good_cnt_n = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if ((state != IDLE) && (cnt_p1_c == TMO_LIM)) begin
      timeout_n  = 1'b1;
      state_n    = IDLE;
      good_cnt_n = '0;
      cnt_n      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      state        <= IDLE;
      cnt          <= '0;
      good_cnt     <= '0;
      sync_rise_q  <= 1'b0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      s1           <= bus.sync_in;
      s2           <= s1;
      s3           <= s2;
      state        <= state_n;
      cnt          <= cnt_n;
      good_cnt     <= good_cnt_n;
      sync_rise_q  <= rise_c;
      period_q     <= period_n;
      period_vld_q <= period_vld_n;
      locked_q     <= (state_n == LOCKED);
      err_q        <= err_n;
      timeout_q    <= timeout_n;
    end
  end

  assign bus.sync_rise  = sync_rise_q;
  assign bus.period     = period_q;
  assign bus.period_vld = period_vld_q;
  assign bus.locked     = locked_q;
  assign bus.err        = err_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_sync_rx_monitor.sv
// Scoreboard bench for sync_rx_monitor: a behavioural model predicts each rise's
// measurement/lock/err outcome and expected timeouts; a negedge monitor compares.
`timescale 1ns/1ps
module tb_sync_rx_monitor;

  localparam int unsigned CNT_W   = 10;
  localparam int          NOM     = 184;
  localparam int          TOLV    = 4;
  localparam int          LOCKN   = 4;
  localparam int          TMO     = 368;

  typedef struct {
    logic vld;
    int   per;
    logic err;
    logic lock;
  } exp_t;

  logic clk;
  logic rst;
  sync_rx_if #(.CNT_W(CNT_W)) bus ();

  sync_rx_monitor #(
    .NOM_PERIOD(NOM), .TOL(TOLV), .LOCK_CNT(LOCKN), .TIMEOUT(TMO), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  int   cyc = 0;
  int   last_drive_cyc = 0;
  int   last_rise_seen = 0;
  int   tmo_seen = 0;

  // behavioural model: 0 = no reference, 1 = acquiring, 2 = locked
  int   m_st = 0;
  int   m_gc = 0;
  int   m_last_period = 0;
  int   m_tmo_exp = 0;

  initial clk = 1'b0;
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Predict the outcome of a rise occurring `elapsed` cycles after the previous one.
  task automatic model_rise(input int elapsed);
    exp_t e;
    logic good;
    if (m_st != 0 && elapsed > TMO) begin
      m_tmo_exp++;
      m_st = 0;
      m_gc = 0;
    end
    e.vld = 1'b0; e.per = 0; e.err = 1'b0;
    if (m_st == 0) begin
      m_st = 1;
      m_gc = 0;
    end else begin
      good = (elapsed >= NOM - TOLV) && (elapsed <= NOM + TOLV);
      e.vld = 1'b1;
      e.per = elapsed;
      m_last_period = elapsed;
      if (!good) begin
        e.err = 1'b1;
        m_st  = 1;
        m_gc  = 0;
      end else if (m_st == 1) begin
        m_gc++;
        if (m_gc == LOCKN) m_st = 2;
      end
    end
    e.lock = (m_st == 2);
    sb_q.push_back(e);
  endtask

  // Rise, then `hi` cycles high and `lo` cycles low, driven on negedges.
  task automatic drive_rise(input int hi, input int lo);
    @(negedge clk);
    model_rise(cyc - last_drive_cyc);
    last_drive_cyc = cyc;
    bus.sync_in = 1'b1;
    repeat (hi) @(negedge clk);
    bus.sync_in = 1'b0;
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic run_period(input int p);
    drive_rise(92, p - 92);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rise"},  int'(bus.sync_rise),  0);
    check({tag, "_per"},   int'(bus.period),     0);
    check({tag, "_vld"},   int'(bus.period_vld), 0);
    check({tag, "_lock"},  int'(bus.locked),     0);
    check({tag, "_err"},   int'(bus.err),        0);
    check({tag, "_tmo"},   int'(bus.timeout),    0);
  endtask

  // Output monitor: pops one expectation per observed rise.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.sync_rise) begin
        if (sb_q.size() == 0) begin
          check("unexpected_rise", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("period_vld", int'(bus.period_vld), int'(e.vld));
          if (e.vld) check("period", int'(bus.period), e.per);
          check("err", int'(bus.err), int'(e.err));
          check("locked", int'(bus.locked), int'(e.lock));
          check("tmo_on_rise", int'(bus.timeout), 0);
        end
        last_rise_seen = cyc;
      end else if (bus.period_vld || bus.err) begin
        check("stray_pulse", int'({bus.period_vld, bus.err}), 0);
      end
      if (bus.timeout) begin
        tmo_seen++;
        check("tmo_delay", cyc - last_rise_seen, TMO);
        check("tmo_locked", int'(bus.locked), 0);
        check("tmo_period", int'(bus.period), m_last_period);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    bus.sync_in = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // nominal acquisition
    repeat (10) run_period(184);
    check("lock_after_10", int'(bus.locked), 1);

    // one long period breaks lock, then reacquire
    run_period(190);
    repeat (5) run_period(184);
    check("relock", int'(bus.locked), 1);

    // tolerance edges
    repeat (3) begin
      run_period(180);
      run_period(188);
    end
    check("lock_tol_edges", int'(bus.locked), 1);

    // loss of SYNC
    run_period(184);
    run_period(400);
    check("tmo_count_mid", tmo_seen, 1);
    check("unlocked_after_tmo", int'(bus.locked), 0);
    repeat (6) run_period(184);

    // rise exactly at the timeout boundary
    run_period(368);
    repeat (6) run_period(184);

    // async reset mid-period while locked, during the low phase
    check("lock_before_rst", int'(bus.locked), 1);
    drive_rise(92, 30);
    #3 rst = 1'b0;
    #1 check_all_zero("async_rst");
    m_st = 0;
    m_gc = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    repeat (6) run_period(184);
    run_period(150);
    repeat (10) @(negedge clk);

    check("tmo_count", tmo_seen, m_tmo_exp);
    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
